mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter RETIRE_CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port mem_ctrl_in, input, ctrl_t: MEM-stage control bundle; uses fields regwrite, memread, memtoreg.
REQ-005 The block SHALL have port mem_valid_in, input, 1: MEM-stage slot holds a real instruction (0 = bubble).
REQ-006 The block SHALL have port mem_alu_in, input, 32: ALU result/effective address.
REQ-007 The block SHALL have port mem_rdata_in, input, 32: full aligned word from data memory, valid in the same cycle as the other mem_* inputs.
REQ-008 The block SHALL have port mem_rd_in, input, 5: destination register.
REQ-009 The block SHALL have port mem_funct3_in, input, 3: load width/sign code.
REQ-010 The block SHALL have port stall, input, 1: hold the MEM/WB register contents.
REQ-011 The block SHALL have port flush, input, 1: load a bubble.
REQ-012 The block SHALL have ports wb_we (output, 1), wb_rd (output, 5) and wb_wdata (output, 32): register-file write port, also used as the forwarding source.
REQ-013 The block SHALL have port wb_load_fault, output, 1: the current WB entry is a faulted load.
REQ-014 The block SHALL have port retire_count, output, RETIRE_CNT_W: count of retired instructions.

Function
REQ-015 On each clk edge with rst=0:
  - flush=1: valid_q<=0 (flush has priority over stall).
  - else stall=1: all registered fields hold.
  - else: ctrl, valid, alu, rdata, rd and funct3 are captured from the mem_* inputs.
REQ-016 Latency SHALL be exactly one cycle from the mem_* inputs to the wb_* outputs; the wb_* outputs are combinational from the registered fields only.
REQ-017 Load formatting SHALL use off = alu_q[1:0] and the registered funct3:
  - 000 LB: sign-extend rdata byte[off].
  - 100 LBU: zero-extend rdata byte[off].
  - 001 LH: sign-extend halfword[off[1]].
  - 101 LHU: zero-extend halfword[off[1]].
  - 010 LW: the full word.
REQ-018 wb_load_fault SHALL be 1 when valid_q & memread_q and any of the following holds:
  - funct3 is 001 or 101 with off[0]=1;
  - funct3 is 010 with off!=0;
  - funct3 is 011, 110 or 111.
REQ-019 wb_wdata SHALL be the formatted load data when memtoreg_q=1, else alu_q; when faulted it SHALL be 0.
REQ-020 wb_we SHALL equal valid_q & regwrite_q & (rd_q!=0) & ~wb_load_fault; wb_rd SHALL equal rd_q.
REQ-021 A retire event SHALL be valid_q & ~wb_load_fault & ~stall; on each retire event retire_count increments by 1, wrapping from 2^RETIRE_CNT_W-1 to 0.
REQ-022 During a stall, wb_we SHALL stay asserted with unchanged wb_rd and wb_wdata, so the idempotent rewrite is legal and the entry is counted once.
REQ-023 When flush and stall are both asserted, the entry currently in WB SHALL NOT count as retired in that cycle and SHALL become a bubble on the next edge.

Reset
REQ-024 On a rst=1 edge: valid_q, all control bits, alu_q, rdata_q, rd_q, funct3_q and retire_count SHALL be 0.
REQ-025 In the first cycle after reset, wb_we=0, wb_rd=0, wb_wdata=0, wb_load_fault=0 and retire_count=0.
REQ-026 rst SHALL override flush and stall, and an asserted rst mid-stall SHALL discard the held entry.

Structure
REQ-027 ctrl_t (with fields regwrite, memread, memwrite, memtoreg) and the localparam funct3 load codes (LB, LH, LW, LBU, LHU) SHALL live in cpu_types.
REQ-028 Load formatting SHALL be a sub-module load_formatter (purely combinational: funct3, off and word in; data and fault out); the pipeline register and counter SHALL stay in mem_wb_stage.

Verification
REQ-029 LB sign extension: rdata=0x80FF7F01, alu=0x103, funct3=000, memtoreg=1, regwrite=1, rd=5 -> next cycle wb_we=1, wb_rd=5, wb_wdata=0xFFFFFF80.
REQ-030 LHU zero extension: same rdata, alu=0x102, funct3=101 -> wb_wdata=0x000080FF.
REQ-031 Misaligned word load: LW with alu=0x101 -> wb_load_fault=1, wb_we=0, wb_wdata=0, retire_count unchanged.
REQ-032 Stall hold: ALU op to rd=3, value 0x1234, stalled 3 cycles -> wb_* stable for 4 cycles and retire_count increments exactly once.
REQ-033 Flush with stall: flush=1 and stall=1 on a valid entry -> next cycle wb_we=0 and no increment; separately, rd=0 with regwrite=1 -> wb_we=0 but retire_count still increments.
REQ-034 Counter wrap and reset: RETIRE_CNT_W=4, 17 retirements -> retire_count=1; then rst=1 during a stall -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/cpu_types.sv
// Shared pipeline types: control bundle, load funct3 codes and extension helpers.
package cpu_types;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: lane select, sign/zero extension and alignment fault.
module load_formatter
  import cpu_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic        fault_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word_i[{off_i, 3'b000} +: 8];
  assign half_s = off_i[1] ? word_i[31:16] : word_i[15:0];

  // Width/sign decode; undefined load codes fault and return zero.
  always_comb begin
    data_o  = 32'd0;
    fault_o = 1'b0;
    case (funct3_i)
      LB:  data_o = sext8(byte_s);
      LBU: data_o = {24'd0, byte_s};
      LH: begin
        data_o  = sext16(half_s);
        fault_o = off_i[0];
      end
      LHU: begin
        data_o  = {16'd0, half_s};
        fault_o = off_i[0];
      end
      LW: begin
        data_o  = word_i;
        fault_o = (off_i != 2'd0);
      end
      default: begin
        data_o  = 32'd0;
        fault_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load formatting, register-file write port and retire counter.
module mem_wb_stage
  import cpu_types::*;
#(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  ctrl_t                   mem_ctrl_in,
  input  logic                    mem_valid_in,
  input  logic [31:0]             mem_alu_in,
  input  logic [31:0]             mem_rdata_in,
  input  logic [4:0]              mem_rd_in,
  input  logic [2:0]              mem_funct3_in,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    wb_we,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_wdata,
  output logic                    wb_load_fault,
  output logic [RETIRE_CNT_W-1:0] retire_count
);

  logic                    valid_q, valid_d;
  logic                    regwrite_q, regwrite_d;
  logic                    memread_q, memread_d;
  logic                    memtoreg_q, memtoreg_d;
  logic [31:0]             alu_q, alu_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [4:0]              rd_q, rd_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] fmt_data_s;
  logic        fmt_fault_s;
  logic        retire_s;
  logic        unused_ctrl_s;

  // Stores are handled upstream; memwrite is not needed in WB.
  assign unused_ctrl_s = mem_ctrl_in.memwrite;

  load_formatter u_fmt (
    .funct3_i (funct3_q),
    .off_i    (alu_q[1:0]),
    .word_i   (rdata_q),
    .data_o   (fmt_data_s),
    .fault_o  (fmt_fault_s)
  );

  assign wb_load_fault = valid_q & memread_q & fmt_fault_s;
  assign wb_wdata      = wb_load_fault ? 32'd0 : (memtoreg_q ? fmt_data_s : alu_q);
  assign wb_rd         = rd_q;
  assign wb_we         = valid_q & regwrite_q & (rd_q != 5'd0) & ~wb_load_fault;
  assign retire_s      = valid_q & ~wb_load_fault & ~stall;
  assign retire_count  = cnt_q;

  // Pipeline-register next state: flush kills the slot, stall holds, otherwise capture.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memtoreg_d = memtoreg_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d    = mem_valid_in;
      regwrite_d = mem_ctrl_in.regwrite;
      memread_d  = mem_ctrl_in.memread;
      memtoreg_d = mem_ctrl_in.memtoreg;
      alu_d      = mem_alu_in;
      rdata_d    = mem_rdata_in;
      rd_d       = mem_rd_in;
      funct3_d   = mem_funct3_in;
    end else begin
      valid_d = valid_q;
    end
  end

  // Retire counter next state; a stalled entry is counted only when it finally leaves.
  always_comb begin
    if (retire_s) begin
      cnt_d = cnt_q + RETIRE_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset overriding flush and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memtoreg_q <= 1'b0;
      alu_q      <= 32'd0;
      rdata_q    <= 32'd0;
      rd_q       <= 5'd0;
      funct3_q   <= 3'd0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memtoreg_q <= memtoreg_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with a 4-bit retire counter.
module tb_mem_wb_stage;
  import cpu_types::*;

  localparam logic [31:0] RDATA = 32'h80FF7F01;

  logic        clk;
  logic        rst;
  ctrl_t       mem_ctrl_in;
  logic        mem_valid_in;
  logic [31:0] mem_alu_in;
  logic [31:0] mem_rdata_in;
  logic [4:0]  mem_rd_in;
  logic [2:0]  mem_funct3_in;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        wb_load_fault;
  logic [3:0]  retire_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_cnt;

  mem_wb_stage #(.RETIRE_CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_ctrl_in   (mem_ctrl_in),
    .mem_valid_in  (mem_valid_in),
    .mem_alu_in    (mem_alu_in),
    .mem_rdata_in  (mem_rdata_in),
    .mem_rd_in     (mem_rd_in),
    .mem_funct3_in (mem_funct3_in),
    .stall         (stall),
    .flush         (flush),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_wdata      (wb_wdata),
    .wb_load_fault (wb_load_fault),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mtr,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [2:0] f3);
    mem_valid_in         = v;
    mem_ctrl_in.regwrite = rw;
    mem_ctrl_in.memread  = mr;
    mem_ctrl_in.memwrite = 1'b0;
    mem_ctrl_in.memtoreg = mtr;
    mem_alu_in           = alu;
    mem_rdata_in         = RDATA;
    mem_rd_in            = rd;
    mem_funct3_in        = f3;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31, 3'b010);
    tick(); tick();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", wb_rd); end
    checks++; if (wb_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", wb_wdata); end
    checks++; if (wb_load_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", wb_load_fault); end
    checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", retire_count); end
    rst = 1'b0; stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0);
    exp_cnt = 4'd0;
  endtask

  task automatic test_lb();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h103, 5'd5, LB);
    tick();
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL lb_we: got %b expected 1", wb_we); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL lb_rd: got %0d expected 5", wb_rd); end
    checks++; if (wb_wdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_wdata: got %h expected ffffff80", wb_wdata); end
    checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL lb_count: got %0d expected %0d", retire_count, exp_cnt); end
  endtask

  task automatic test_lhu();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h102, 5'd6, LHU);
    tick(); exp_cnt++;
    checks++; if (wb_wdata !== 32'h000080FF) begin errors++; $display("FAIL lhu_wdata: got %h expected 000080ff", wb_wdata); end
    checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL lhu_count: got %0d expected %0d", retire_count, exp_cnt); end
  endtask

  task automatic test_formats();
    logic [2:0]  f3_tab  [6];
    logic [31:0] alu_tab [6];
    logic [31:0] exp_tab [6];
    f3_tab[0] = LH;  alu_tab[0] = 32'h200; exp_tab[0] = 32'h00007F01;
    f3_tab[1] = LH;  alu_tab[1] = 32'h202; exp_tab[1] = 32'hFFFF80FF;
    f3_tab[2] = LBU; alu_tab[2] = 32'h202; exp_tab[2] = 32'h000000FF;
    f3_tab[3] = LB;  alu_tab[3] = 32'h201; exp_tab[3] = 32'h0000007F;
    f3_tab[4] = LW;  alu_tab[4] = 32'h204; exp_tab[4] = 32'h80FF7F01;
    f3_tab[5] = LBU; alu_tab[5] = 32'h203; exp_tab[5] = 32'h00000080;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, alu_tab[i], 5'd7, f3_tab[i]);
      tick(); exp_cnt++;
      checks++; if (wb_wdata !== exp_tab[i]) begin errors++; $display("FAIL fmt%0d_wdata: got %h expected %h", i, wb_wdata, exp_tab[i]); end
      checks++; if (wb_load_fault !== 1'b0) begin errors++; $display("FAIL fmt%0d_fault: got %b expected 0", i, wb_load_fault); end
    end
    checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL fmt_count: got %0d expected %0d", retire_count, exp_cnt); end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3_tab  [3];
    logic [31:0] alu_tab [3];
    f3_tab[0] = LW;     alu_tab[0] = 32'h101;
    f3_tab[1] = LH;     alu_tab[1] = 32'h103;
    f3_tab[2] = 3'b011; alu_tab[2] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, alu_tab[i], 5'd8, f3_tab[i]);
      tick();
      if (i == 0) exp_cnt++;
      checks++; if (wb_load_fault !== 1'b1) begin errors++; $display("FAIL mis%0d_fault: got %b expected 1", i, wb_load_fault); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL mis%0d_we: got %b expected 0", i, wb_we); end
      checks++; if (wb_wdata !== 32'd0) begin errors++; $display("FAIL mis%0d_wdata: got %h expected 0", i, wb_wdata); end
      checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL mis%0d_count: got %0d expected %0d", i, retire_count, exp_cnt); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0);
    tick();
    checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL mis_after_count: got %0d expected %0d", retire_count, exp_cnt); end
  endtask

  task automatic test_stall_hold();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 5'd3, 3'd0);
    tick();
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD, 5'd9, LB);
    for (int c = 0; c < 4; c++) begin
      checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd3 || wb_wdata !== 32'h1234)
        begin errors++; $display("FAIL stall%0d_hold: got we=%b rd=%0d wdata=%h expected 1/3/00001234", c, wb_we, wb_rd, wb_wdata); end
      checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL stall%0d_count: got %0d expected %0d", c, retire_count, exp_cnt); end
      if (c < 3) tick();
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0);
    tick(); exp_cnt++;
    checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL stall_release_count: got %0d expected %0d", retire_count, exp_cnt); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL stall_release_we: got %b expected 0", wb_we); end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 5'd4, 3'd0);
    tick();
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL fs_pre_we: got %b expected 1", wb_we); end
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL fs_we: got %b expected 0", wb_we); end
    checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL fs_count: got %0d expected %0d", retire_count, exp_cnt); end
    flush = 1'b0; stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 5'd0, 3'd0);
    tick();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b expected 0", wb_we); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0);
    tick(); exp_cnt++;
    checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL rd0_count: got %0d expected %0d", retire_count, exp_cnt); end
  endtask

  task automatic test_back_to_back_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 4'd0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'(i + 16), 5'd1, 3'd0);
      tick();
      checks++; if (wb_wdata !== 32'(i + 16)) begin errors++; $display("FAIL b2b%0d_wdata: got %h expected %h", i, wb_wdata, 32'(i + 16)); end
      if (i == 16) begin
        checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", retire_count); end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0);
    tick();
    checks++; if (retire_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", retire_count); end
  endtask

  task automatic test_reset_in_stall();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hAB, 5'd2, 3'd0);
    tick();
    stall = 1'b1;
    tick();
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd2) begin errors++; $display("FAIL rs_held: got we=%b rd=%0d expected 1/2", wb_we, wb_rd); end
    rst = 1'b1;
    tick();
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_wdata !== 32'd0 || wb_load_fault !== 1'b0 || retire_count !== 4'd0)
      begin errors++; $display("FAIL rs_outputs: got we=%b rd=%0d wdata=%h fault=%b cnt=%0d expected all 0", wb_we, wb_rd, wb_wdata, wb_load_fault, retire_count); end
    rst = 1'b0; stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0);
    tick();
    checks++; if (wb_we !== 1'b0 || retire_count !== 4'd0) begin errors++; $display("FAIL rs_after: got we=%b cnt=%0d expected 0/0", wb_we, retire_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 3'd0);
    exp_cnt = 4'd0;
    test_reset();
    test_lb();
    test_lhu();
    test_formats();
    test_misaligned();
    test_stall_hold();
    test_flush_stall();
    test_back_to_back_wrap();
    test_reset_in_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
